// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and capture-FSM state encoding for the UART
// receive FIFO.
// Contents: default word width / depth, FSM state codes and state enum.
package uart_pkg;

    localparam int unsigned WIDTH_DATA_DEF = 8;
    localparam int unsigned DEPTH_LOG2_DEF = 4;

    // Fixed state codes, kept as plain constants so older tools and probes
    // can decode the state register without the enum type.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ACK  = ST_ACK,
        WAIT = ST_WAIT
    } state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side and consumer-side signals of uart_rx_fifo.
// Signals: i_uart_rdy/i_uart_data/o_uart_re (receiver handshake),
//          o_data/o_valid/i_ready (show-ahead consumer handshake),
//          o_count/o_full (status), o_ovf/i_clr_ovf (overrun flag, only when
//          UART_RX_FIFO_OVF_EN is defined).
// Modports: slave = FIFO view, master = environment view.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEF,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
);
    logic                  i_uart_rdy;
    logic [WIDTH_DATA-1:0] i_uart_data;
    logic                  o_uart_re;
    logic [WIDTH_DATA-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [DEPTH_LOG2:0]   o_count;
    logic                  o_full;
`ifdef UART_RX_FIFO_OVF_EN
    logic                  o_ovf;
    logic                  i_clr_ovf;

    modport slave (
        input  i_uart_rdy, i_uart_data, i_ready, i_clr_ovf,
        output o_uart_re, o_data, o_valid, o_count, o_full, o_ovf
    );
    modport master (
        output i_uart_rdy, i_uart_data, i_ready, i_clr_ovf,
        input  o_uart_re, o_data, o_valid, o_count, o_full, o_ovf
    );
`else
    modport slave (
        input  i_uart_rdy, i_uart_data, i_ready,
        output o_uart_re, o_data, o_valid, o_count, o_full
    );
    modport master (
        output i_uart_rdy, i_uart_data, i_ready,
        input  o_uart_re, o_data, o_valid, o_count, o_full
    );
`endif
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: storage array for the receive FIFO.
// Ports: clk; we/waddr/wdata (single synchronous write port);
//        raddr/rdata (asynchronous read port). Contents are not reset.
module uart_fifo_mem #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: pulls words from the UART receiver with a one-cycle read
// strobe and buffers them in a circular FIFO with a show-ahead consumer port.
// Ports: i_clk, i_srst (synchronous, active high), bus (uart_rx_fifo_if.slave).
// Option: UART_RX_FIFO_OVF_EN -- when defined, a word arriving on a full FIFO
// is strobed and dropped and the sticky o_ovf flag is raised; otherwise the
// word is left in the receiver (back-pressure).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEF,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic           i_clk,
    input  logic           i_srst,
    uart_rx_fifo_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    state_e                  state_q;
    state_e                  state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [CW-1:0]           count;
    logic                    re_q;
    logic [WIDTH_DATA-1:0]   rd_word;

    logic full_c;
    logic valid_c;
    logic push_c;
    logic pop_c;
    logic overrun_c;

    // Full is judged on the registered count, so a pop in the same cycle
    // does not free space until the next cycle.
    assign full_c  = (count == CW'(DEPTH));
    assign valid_c = (count != '0);
    assign push_c  = (state_q == IDLE) && bus.i_uart_rdy && !full_c;
    assign pop_c   = valid_c && bus.i_ready;
`ifdef UART_RX_FIFO_OVF_EN
    assign overrun_c = (state_q == IDLE) && bus.i_uart_rdy && full_c;
`else
    assign overrun_c = 1'b0;
`endif

    // Capture FSM next state: one strobe per receiver word, then wait for
    // the receiver to drop its flag before looking again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push_c || overrun_c) state_d = ACK;
            ACK:     state_d = WAIT;
            WAIT:    if (!bus.i_uart_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, pointers, occupancy and registered strobe.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            re_q    <= (state_d == ACK);
            if (push_c) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop_c)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef UART_RX_FIFO_OVF_EN
    logic ovf_q;

    // Sticky overrun: a new overrun takes priority over a clear.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            ovf_q <= 1'b0;
        end else if (overrun_c) begin
            ovf_q <= 1'b1;
        end else if (bus.i_clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.o_ovf = ovf_q;
`endif

    uart_fifo_mem #(
        .WIDTH  (WIDTH_DATA),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk   (i_clk),
        .we    (push_c),
        .waddr (wr_ptr),
        .wdata (bus.i_uart_data),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    assign bus.o_uart_re = re_q;
    assign bus.o_data    = valid_c ? rd_word : '0;
    assign bus.o_valid   = valid_c;
    assign bus.o_count   = count;
    assign bus.o_full    = full_c;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo. A receiver model
// offers words; expected words go into a scoreboard queue and a monitor pops
// and compares on every consumer handshake.
module tb_uart_rx_fifo;
    localparam int unsigned WD    = 8;
    localparam int unsigned DL    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic srst;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.WIDTH_DATA(WD), .DEPTH_LOG2(DL)) bus ();

    uart_rx_fifo #(.WIDTH_DATA(WD), .DEPTH_LOG2(DL)) dut (
        .i_clk  (clk),
        .i_srst (srst),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;
    logic [WD-1:0] exp_q [$];
    bit done;
    bit got;
    int s0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver model: hold the word until strobed (or timeout), then drop the
    // flag and leave it low for a cycle.
    task automatic send_word(input logic [WD-1:0] d, input int tmo, output bit ok);
        ok = 1'b0;
        bus.i_uart_rdy  = 1'b1;
        bus.i_uart_data = d;
        for (int i = 0; i < tmo; i++) begin
            @(negedge clk);
            if (bus.o_uart_re) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.i_uart_rdy = 1'b0;
        tick();
    endtask

    task automatic drain();
        bit emptied;
        emptied = 1'b0;
        tick();
        bus.i_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.o_valid) begin
                emptied = 1'b1;
                break;
            end
        end
        chk("drain_done", 32'(emptied), 1);
        tick();
        bus.i_ready = 1'b0;
        @(negedge clk);
        chk("drain_count", 32'(bus.o_count), 0);
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (bus.o_uart_re) strobes++;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!srst) begin
            if (bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected actual=0x%0h required=no_word", bus.o_data);
                end else begin
                    chk("pop_data", 32'(bus.o_data), 32'(exp_q.pop_front()));
                end
            end
            if (!bus.o_valid) chk("empty_data_zero", 32'(bus.o_data), 0);
        end
    end

    initial begin
        srst            = 1'b1;
        bus.i_uart_rdy  = 1'b0;
        bus.i_uart_data = '0;
        bus.i_ready     = 1'b0;
`ifdef UART_RX_FIFO_OVF_EN
        bus.i_clr_ovf   = 1'b0;
`endif
        done = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_re", 32'(bus.o_uart_re), 0);
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_data", 32'(bus.o_data), 0);
        chk("rst_count", 32'(bus.o_count), 0);
        chk("rst_full", 32'(bus.o_full), 0);
`ifdef UART_RX_FIFO_OVF_EN
        chk("rst_ovf", 32'(bus.o_ovf), 0);
`endif
        tick();
        srst = 1'b0;

        // Single word 0xA5: capture latency and pop.
        tick();
        s0 = strobes;
        bus.i_uart_rdy  = 1'b1;
        bus.i_uart_data = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        chk("a5_re_before", 32'(bus.o_uart_re), 0);
        tick();
        bus.i_uart_rdy = 1'b0;
        @(negedge clk);
        chk("a5_re", 32'(bus.o_uart_re), 1);
        chk("a5_valid", 32'(bus.o_valid), 1);
        chk("a5_data", 32'(bus.o_data), 32'h A5);
        chk("a5_count", 32'(bus.o_count), 1);
        tick();
        @(negedge clk);
        chk("a5_re_one_cycle", 32'(bus.o_uart_re), 0);
        tick();
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        @(negedge clk);
        chk("a5_valid_after_pop", 32'(bus.o_valid), 0);
        chk("a5_count_after_pop", 32'(bus.o_count), 0);
        chk("a5_strobes", strobes - s0, 1);

        // Flag held high for 10 cycles: exactly one capture.
        tick();
        s0 = strobes;
        bus.i_uart_rdy  = 1'b1;
        bus.i_uart_data = 8'h3C;
        exp_q.push_back(8'h3C);
        repeat (10) tick();
        bus.i_uart_rdy = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("hold_strobes", strobes - s0, 1);
        chk("hold_count", 32'(bus.o_count), 1);
        drain();

        // Fill to full with 0x00..0x0F.
        tick();
        for (int w = 0; w < 16; w++) begin
            exp_q.push_back(8'(w));
            send_word(8'(w), 10, got);
            chk("fill_strobe", 32'(got), 1);
        end
        @(negedge clk);
        chk("fill_count", 32'(bus.o_count), DEPTH);
        chk("fill_full", 32'(bus.o_full), 1);
        tick();
`ifdef UART_RX_FIFO_OVF_EN
        // 17th word is strobed and dropped; overrun flag set then cleared.
        send_word(8'h10, 10, got);
        chk("ovf_strobe", 32'(got), 1);
        @(negedge clk);
        chk("ovf_set", 32'(bus.o_ovf), 1);
        chk("ovf_count", 32'(bus.o_count), DEPTH);
        tick();
        bus.i_clr_ovf = 1'b1;
        tick();
        bus.i_clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 32'(bus.o_ovf), 0);
        drain();
`else
        // 17th word waits in the receiver; a pop lets it in one cycle later.
        s0 = strobes;
        bus.i_uart_rdy  = 1'b1;
        bus.i_uart_data = 8'h10;
        exp_q.push_back(8'h10);
        repeat (10) tick();
        @(negedge clk);
        chk("bp_no_strobe", strobes - s0, 0);
        chk("bp_count", 32'(bus.o_count), DEPTH);
        chk("bp_full", 32'(bus.o_full), 1);
        tick();
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_cycle_re", 32'(bus.o_uart_re), 0);
        tick();
        bus.i_ready = 1'b0;
        @(negedge clk);
        chk("bp_deferred_count", 32'(bus.o_count), DEPTH - 1);
        chk("bp_deferred_re", 32'(bus.o_uart_re), 0);
        tick();
        @(negedge clk);
        chk("bp_push_re", 32'(bus.o_uart_re), 1);
        chk("bp_push_count", 32'(bus.o_count), DEPTH);
        tick();
        bus.i_uart_rdy = 1'b0;
        drain();
`endif

        // Pointer wrap: 40 words with random consumer readiness.
        tick();
        done = 1'b0;
        fork
            begin
                for (int w = 0; w < 40; w++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    for (int i = 0; i < 200 && bus.o_full; i++) tick();
                    exp_q.push_back(8'(w));
                    send_word(8'(w), 50, got);
                    chk("wrap_strobe", 32'(got), 1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.i_ready = ($urandom_range(0, 1) == 1);
                    tick();
                end
                bus.i_ready = 1'b0;
            end
        join
        drain();

        // Reset during ACK with 5 words stored.
        tick();
        for (int w = 0; w < 5; w++) begin
            exp_q.push_back(8'(8'h50 + w));
            send_word(8'(8'h50 + w), 10, got);
        end
        bus.i_uart_rdy  = 1'b1;
        bus.i_uart_data = 8'h55;
        tick();
        @(negedge clk);
        chk("srst_pre_re", 32'(bus.o_uart_re), 1);
        chk("srst_pre_count", 32'(bus.o_count), 6);
        srst = 1'b1;
        exp_q.delete();
        tick();
        srst = 1'b0;
        bus.i_uart_rdy = 1'b0;
        @(negedge clk);
        chk("srst_re", 32'(bus.o_uart_re), 0);
        chk("srst_count", 32'(bus.o_count), 0);
        chk("srst_valid", 32'(bus.o_valid), 0);

        // Still functional after reset.
        tick();
        exp_q.push_back(8'h77);
        send_word(8'h77, 10, got);
        chk("post_srst_strobe", 32'(got), 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
